// File: rtl/segasys1_pkg.sv
// Shared types and defaults for the SEGA System 1 sound-command receiver.
// Holds the NMI sequencer state encoding and the default IRQ timing constants.
package segasys1_pkg;

  typedef enum logic [1:0] {
    N_IDLE   = 2'd0,
    N_ASSERT = 2'd1,
    N_WAIT   = 2'd2
  } nmi_state_e;

  localparam int IRQ_DIV_DEF = 160000;
  localparam int IRQ_LEN_DEF = 4096;
  localparam int IRQ_CNT_W   = 18;

endpackage

// File: rtl/segasys1_cmd_fifo.sv
// Register-based command byte FIFO with combinational head; push/pop take effect on the next edge.
// A push into a full FIFO is dropped (reported on drop) unless a pop frees the slot in the same cycle.
module segasys1_cmd_fifo #(
  parameter int DEPTH_LG = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [7:0]          push_dat,
  input  logic                pop,
  output logic [7:0]          head_dat,
  output logic                empty,
  output logic [DEPTH_LG:0]   level,
  output logic                pop_acc,
  output logic                drop
);

  localparam int DEPTH = 1 << DEPTH_LG;

  logic [DEPTH_LG:0] wptr_q, wptr_d;
  logic [DEPTH_LG:0] rptr_q, rptr_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic              full;
  logic              push_acc;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[DEPTH_LG] != rptr_q[DEPTH_LG]) &&
                    (wptr_q[DEPTH_LG-1:0] == rptr_q[DEPTH_LG-1:0]);
  assign level    = wptr_q - rptr_q;
  assign head_dat = mem_q[rptr_q[DEPTH_LG-1:0]];
  assign pop_acc  = pop & ~empty;
  // A same-cycle pop frees exactly the slot the push lands in.
  assign push_acc = push & (~full | pop_acc);
  assign drop     = push & ~push_acc;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (pop_acc) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push_acc) begin
      mem_d[wptr_q[DEPTH_LG-1:0]] = push_dat;
      wptr_d = wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/segasys1_sndcmd_rx.sv
// Sound-side command receiver: queues main-CPU sound requests, raises NMI while pending, times sound IRQ.
// Pop lands one cycle after the read access ends; commands arriving while full are dropped and flagged on OVF.
module segasys1_sndcmd_rx
  import segasys1_pkg::*;
#(
  parameter int DEPTH_LG = 2,
  parameter int IRQ_DIV  = IRQ_DIV_DEF,
  parameter int IRQ_LEN  = IRQ_LEN_DEF
) (
  input  logic                CLK40M,
  input  logic                RESET_N,
  input  logic                SNDRQ,
  input  logic [7:0]          SNDNO,
  input  logic                SCPU_CS,
  input  logic                SCPU_RD,
  input  logic                SCPU_IACK,
  output logic [7:0]          SCMD_DO,
  output logic                SNMI,
  output logic                SIRQ,
  output logic                OVF,
  output logic [DEPTH_LG:0]   LEVEL
);

  localparam int LEN_W = $clog2(IRQ_LEN + 1);

  logic                 rd_act;
  logic                 rd_prev_q, rd_prev_d;
  logic                 stale_q, stale_d;
  logic [7:0]           last_q, last_d;
  logic                 ovf_q, ovf_d;
  logic                 snmi_q, snmi_d;
  nmi_state_e           state_q, state_d;
  logic                 sirq_q, sirq_d;
  logic [IRQ_CNT_W-1:0] irq_cnt_q, irq_cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 irq_wrap;

  logic                 pop_req;
  logic [7:0]           fifo_head;
  logic                 fifo_empty;
  logic [DEPTH_LG:0]    fifo_level;
  logic                 fifo_pop_acc;
  logic                 fifo_drop;

  assign rd_act  = SCPU_CS & SCPU_RD;
  // An access that began on an empty queue must not consume a byte pushed mid-access.
  assign pop_req = rd_prev_q & ~rd_act & ~stale_q;

  segasys1_cmd_fifo #(
    .DEPTH_LG (DEPTH_LG)
  ) u_fifo (
    .clk      (CLK40M),
    .rst_n    (RESET_N),
    .push     (SNDRQ),
    .push_dat (SNDNO),
    .pop      (pop_req),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .pop_acc  (fifo_pop_acc),
    .drop     (fifo_drop)
  );

  assign SCMD_DO = (fifo_empty | stale_q) ? last_q : fifo_head;
  assign SNMI    = snmi_q;
  assign SIRQ    = sirq_q;
  assign OVF     = ovf_q;
  assign LEVEL   = fifo_level;

  always_comb begin
    rd_prev_d = rd_act;
    stale_d   = rd_act & (rd_prev_q ? stale_q : fifo_empty);
    last_d    = fifo_pop_acc ? fifo_head : last_q;
    ovf_d     = ovf_q | fifo_drop;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      N_IDLE:   if (fifo_level != '0) state_d = N_ASSERT;
      N_ASSERT: if (fifo_pop_acc) state_d = N_WAIT;
      N_WAIT:   state_d = N_IDLE;
      default:  state_d = N_IDLE;
    endcase
    snmi_d = (state_d == N_ASSERT);
  end

  assign irq_wrap = (irq_cnt_q == IRQ_CNT_W'(IRQ_DIV - 1));

  always_comb begin
    irq_cnt_d = irq_wrap ? '0 : irq_cnt_q + 1'b1;
    sirq_d    = sirq_q;
    len_d     = len_q;
    if (irq_wrap) begin
      sirq_d = 1'b1;
      len_d  = '0;
    end else if (sirq_q) begin
      if (SCPU_IACK || (len_q == LEN_W'(IRQ_LEN - 1))) begin
        sirq_d = 1'b0;
        len_d  = '0;
      end else begin
        len_d = len_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK40M or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_prev_q <= 1'b0;
      stale_q   <= 1'b0;
      last_q    <= 8'h00;
      ovf_q     <= 1'b0;
      snmi_q    <= 1'b0;
      state_q   <= N_IDLE;
      sirq_q    <= 1'b0;
      irq_cnt_q <= '0;
      len_q     <= '0;
    end else begin
      rd_prev_q <= rd_prev_d;
      stale_q   <= stale_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      snmi_q    <= snmi_d;
      state_q   <= state_d;
      sirq_q    <= sirq_d;
      irq_cnt_q <= irq_cnt_d;
      len_q     <= len_d;
    end
  end

endmodule

// File: tb/tb_segasys1_sndcmd_rx.sv
// Bench for segasys1_sndcmd_rx: directed scenarios plus a randomized run against a queue-based model.
module tb_segasys1_sndcmd_rx;

  localparam int DEPTH_LG = 2;
  localparam int DEPTH    = 4;
  localparam int IRQ_DIV  = 200;
  localparam int IRQ_LEN  = 30;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                sndrq = 1'b0;
  logic [7:0]          sndno = 8'h00;
  logic                cs = 1'b0;
  logic                rd = 1'b0;
  logic                iack = 1'b0;
  logic [7:0]          scmd_do;
  logic                snmi;
  logic                sirq;
  logic                ovf;
  logic [DEPTH_LG:0]   level;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] q[$];
  logic [7:0] m_last;
  bit         m_ovf;

  segasys1_sndcmd_rx #(
    .DEPTH_LG (DEPTH_LG),
    .IRQ_DIV  (IRQ_DIV),
    .IRQ_LEN  (IRQ_LEN)
  ) dut (
    .CLK40M    (clk),
    .RESET_N   (rst_n),
    .SNDRQ     (sndrq),
    .SNDNO     (sndno),
    .SCPU_CS   (cs),
    .SCPU_RD   (rd),
    .SCPU_IACK (iack),
    .SCMD_DO   (scmd_do),
    .SNMI      (snmi),
    .SIRQ      (sirq),
    .OVF       (ovf),
    .LEVEL     (level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    sndrq = 1'b0; cs = 1'b0; rd = 1'b0; iack = 1'b0; sndno = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    m_last = 8'h00;
    m_ovf  = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk); #1;
    sndrq = 1'b1; sndno = b;
    @(posedge clk); #1;
    sndrq = 1'b0;
    if (q.size() < DEPTH) q.push_back(b); else m_ovf = 1'b1;
  endtask

  // Full read access on a non-empty queue; optional push lands on the pop edge.
  task automatic do_read(input int hold, input bit co_push, input logic [7:0] co_byte,
                         output logic [7:0] seen);
    @(posedge clk); #1;
    cs = 1'b1; rd = 1'b1;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    seen = scmd_do;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    if (co_push) begin sndrq = 1'b1; sndno = co_byte; end
    @(posedge clk); #1;
    sndrq = 1'b0;
    if (q.size() > 0) m_last = q.pop_front();
    if (co_push) begin
      if (q.size() < DEPTH) q.push_back(co_byte); else m_ovf = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_total++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
    n_total++; if (snmi !== 1'b0) $display("FAIL reset_snmi: got %b want 0", snmi); else n_pass++;
    n_total++; if (sirq !== 1'b0) $display("FAIL reset_sirq: got %b want 0", sirq); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
    n_total++; if (scmd_do !== 8'h00) $display("FAIL reset_do: got %h want 00", scmd_do); else n_pass++;
  endtask

  task automatic test_irq_idle();
    int sirq_err = 0;
    int idle_err = 0;
    bit exp;
    do_reset();
    for (int n = 1; n <= 2 * IRQ_DIV + IRQ_LEN + 5; n++) begin
      @(posedge clk);
      @(negedge clk);
      exp = ((n >= IRQ_DIV) && (n < IRQ_DIV + IRQ_LEN)) ||
            ((n >= 2 * IRQ_DIV) && (n < 2 * IRQ_DIV + IRQ_LEN));
      if (sirq !== exp) sirq_err++;
      if (snmi !== 1'b0 || level !== 3'd0) idle_err++;
      if (n == IRQ_DIV - 1 || n == 2 * IRQ_DIV - 1) begin
        n_total++; if (sirq !== 1'b0) $display("FAIL irq_pre_edge n=%0d: got %b want 0", n, sirq); else n_pass++;
      end
      if (n == IRQ_DIV || n == 2 * IRQ_DIV) begin
        n_total++; if (sirq !== 1'b1) $display("FAIL irq_rise n=%0d: got %b want 1", n, sirq); else n_pass++;
      end
    end
    n_total++; if (sirq_err !== 0) $display("FAIL irq_pattern: %0d cycles wrong, want 0", sirq_err); else n_pass++;
    n_total++; if (idle_err !== 0) $display("FAIL idle_quiet: %0d cycles with nmi/level set, want 0", idle_err); else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] seen;
    do_reset();
    push_byte(8'h5A);
    @(negedge clk);
    n_total++; if (level !== 3'd1) $display("FAIL single_level: got %0d want 1", level); else n_pass++;
    @(posedge clk); @(negedge clk);
    n_total++; if (snmi !== 1'b1) $display("FAIL single_nmi: got %b want 1", snmi); else n_pass++;
    do_read(2, 1'b0, 8'h00, seen);
    n_total++; if (seen !== 8'h5A) $display("FAIL single_data: got %h want 5a", seen); else n_pass++;
    @(negedge clk);
    n_total++; if (snmi !== 1'b0) $display("FAIL single_nmi_clr: got %b want 0", snmi); else n_pass++;
    n_total++; if (level !== 3'd0) $display("FAIL single_level_after: got %0d want 0", level); else n_pass++;
    n_total++; if (scmd_do !== 8'h5A) $display("FAIL single_hold_last: got %h want 5a", scmd_do); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] seen;
    logic [7:0] exp;
    int w;
    do_reset();
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) begin
      sndrq = 1'b1; sndno = 8'(i);
      @(posedge clk); #1;
      if (q.size() < DEPTH) q.push_back(8'(i)); else m_ovf = 1'b1;
    end
    sndrq = 1'b0;
    @(negedge clk);
    n_total++; if (level !== 3'(q.size())) $display("FAIL ovf_level: got %0d want %0d", level, q.size()); else n_pass++;
    n_total++; if (ovf !== m_ovf) $display("FAIL ovf_flag: got %b want %b", ovf, m_ovf); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (snmi !== 1'b1 && w < 10) begin @(negedge clk); w++; end
      n_total++; if (snmi !== 1'b1) $display("FAIL ovf_nmi_rearm read=%0d: got %b want 1", k, snmi); else n_pass++;
      exp = q[0];
      do_read(1 + k, 1'b0, 8'h00, seen);
      n_total++; if (seen !== exp) $display("FAIL ovf_data read=%0d: got %h want %h", k, seen, exp); else n_pass++;
      @(negedge clk);
      n_total++; if (snmi !== 1'b0) $display("FAIL ovf_nmi_low read=%0d: got %b want 0", k, snmi); else n_pass++;
    end
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else n_pass++;
  endtask

  task automatic test_full_pop_push();
    logic [7:0] seen;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(1, 255)));
    exp = q[0];
    do_read(2, 1'b1, 8'hAA, seen);
    @(negedge clk);
    n_total++; if (seen !== exp) $display("FAIL fullpp_data: got %h want %h", seen, exp); else n_pass++;
    n_total++; if (level !== 3'(q.size())) $display("FAIL fullpp_level: got %0d want %0d", level, q.size()); else n_pass++;
    n_total++; if (ovf !== m_ovf) $display("FAIL fullpp_ovf: got %b want %b", ovf, m_ovf); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      exp = q[0];
      do_read(1, 1'b0, 8'h00, seen);
      n_total++; if (seen !== exp) $display("FAIL fullpp_drain read=%0d: got %h want %h", k, seen, exp); else n_pass++;
    end
    n_total++; if (seen !== 8'hAA) $display("FAIL fullpp_last: got %h want aa", seen); else n_pass++;
  endtask

  task automatic test_push_during_read();
    logic [7:0] seen;
    logic [7:0] x;
    logic [7:0] y;
    x = 8'($urandom_range(1, 255));
    y = ~x;
    do_reset();
    push_byte(x);
    do_read(1, 1'b0, 8'h00, seen);
    @(posedge clk); #1;
    cs = 1'b1; rd = 1'b1;
    @(posedge clk); #1;
    sndrq = 1'b1; sndno = y;
    @(posedge clk); #1;
    sndrq = 1'b0;
    q.push_back(y);
    @(negedge clk);
    n_total++; if (scmd_do !== m_last) $display("FAIL pdr_old_data: got %h want %h", scmd_do, m_last); else n_pass++;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (level !== 3'd1) $display("FAIL pdr_no_pop: got %0d want 1", level); else n_pass++;
    do_read(1, 1'b0, 8'h00, seen);
    n_total++; if (seen !== y) $display("FAIL pdr_new_data: got %h want %h", seen, y); else n_pass++;
  endtask

  task automatic test_irq_ack();
    int w;
    int cnt;
    do_reset();
    w = 0;
    @(negedge clk);
    while (sirq !== 1'b1 && w < IRQ_DIV + 10) begin @(negedge clk); w++; end
    n_total++; if (sirq !== 1'b1) $display("FAIL irq_first_rise: got %b want 1", sirq); else n_pass++;
    repeat (9) @(negedge clk);
    @(posedge clk); #1;
    iack = 1'b1;
    @(negedge clk);
    n_total++; if (sirq !== 1'b1) $display("FAIL irq_before_ack: got %b want 1", sirq); else n_pass++;
    @(posedge clk); #1;
    iack = 1'b0;
    @(negedge clk);
    n_total++; if (sirq !== 1'b0) $display("FAIL irq_ack_clear: got %b want 0", sirq); else n_pass++;
    w = 0;
    while (sirq !== 1'b1 && w < IRQ_DIV + 10) begin @(negedge clk); w++; end
    n_total++; if (sirq !== 1'b1) $display("FAIL irq_second_rise: got %b want 1", sirq); else n_pass++;
    cnt = 0;
    while (sirq === 1'b1 && cnt < 2 * IRQ_LEN) begin cnt++; @(negedge clk); end
    n_total++; if (cnt !== IRQ_LEN) $display("FAIL irq_len: high %0d cycles want %0d", cnt, IRQ_LEN); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w;
    int errs = 0;
    do_reset();
    push_byte(8'($urandom_range(1, 255)));
    push_byte(8'($urandom_range(1, 255)));
    w = 0;
    @(negedge clk);
    while (snmi !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    n_total++; if (snmi !== 1'b1 || level !== 3'd2)
      $display("FAIL rmid_pre: got nmi=%b level=%0d want nmi=1 level=2", snmi, level); else n_pass++;
    @(posedge clk); #1;
    cs = 1'b1; rd = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (level !== 3'd0) $display("FAIL rmid_level: got %0d want 0", level); else n_pass++;
    n_total++; if (snmi !== 1'b0) $display("FAIL rmid_snmi: got %b want 0", snmi); else n_pass++;
    n_total++; if (scmd_do !== 8'h00) $display("FAIL rmid_do: got %h want 00", scmd_do); else n_pass++;
    n_total++; if (sirq !== 1'b0 || ovf !== 1'b0) $display("FAIL rmid_irq_ovf: got sirq=%b ovf=%b want 0 0", sirq, ovf); else n_pass++;
    cs = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete(); m_last = 8'h00; m_ovf = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (snmi !== 1'b0 || level !== 3'd0) errs++;
    end
    n_total++; if (errs !== 0) $display("FAIL rmid_after: %0d cycles with nmi/level set, want 0", errs); else n_pass++;
  endtask

  task automatic test_random();
    bit in_acc = 1'b0;
    bit prev_rd = 1'b0;
    bit stale = 1'b0;
    bit push;
    bit pop_now;
    int acc_left = 0;
    int r;
    logic [7:0] b;
    logic [7:0] exp_do;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (in_acc) begin
        if (acc_left == 0) begin in_acc = 1'b0; cs = 1'b0; rd = 1'b0; end
        else acc_left--;
      end else if ($urandom_range(0, 3) == 0) begin
        in_acc = 1'b1; acc_left = $urandom_range(0, 3); cs = 1'b1; rd = 1'b1;
      end else begin
        r  = $urandom_range(0, 9);
        cs = (r == 0);
        rd = (r == 1);
      end
      push  = ($urandom_range(0, 2) == 0);
      b     = 8'($urandom);
      sndrq = push;
      sndno = b;
      if (in_acc && !prev_rd) stale = (q.size() == 0);
      @(negedge clk);
      exp_do = (q.size() == 0 || (stale && (in_acc || prev_rd))) ? m_last : q[0];
      n_total++; if (level !== 3'(q.size())) $display("FAIL rnd_level cyc=%0d: got %0d want %0d", cyc, level, q.size()); else n_pass++;
      n_total++; if (ovf !== m_ovf) $display("FAIL rnd_ovf cyc=%0d: got %b want %b", cyc, ovf, m_ovf); else n_pass++;
      n_total++; if (scmd_do !== exp_do) $display("FAIL rnd_do cyc=%0d: got %h want %h", cyc, scmd_do, exp_do); else n_pass++;
      pop_now = prev_rd && !in_acc && !stale && (q.size() > 0);
      if (pop_now) m_last = q.pop_front();
      if (push) begin
        if (q.size() < DEPTH) q.push_back(b); else m_ovf = 1'b1;
      end
      prev_rd = in_acc;
    end
    @(posedge clk); #1;
    sndrq = 1'b0; cs = 1'b0; rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_irq_idle();
    test_single();
    test_overflow();
    test_full_pop_push();
    test_push_during_read();
    test_irq_ack();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
